// File: rtl/sram_1kx8_sync.sv
`timescale 1ns/1ps
// sram_1kx8_sync
// Single-port clocked 1K x 8 scratch RAM with a shared bidirectional data bus.
// After reset a built-in sweep writes zero to every word. Host accesses are
// ignored while busy is high.
// Reads have one cycle of latency. The bus is driven only while a read is both
// registered and still requested, so a turnaround to write releases it at once.
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per word
// and flag parity_error on reads. Without it, parity_error is tied to 0.
module sram_1kx8_sync #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_select,
    input  logic                  read_write_select,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data_io,
    output logic                  busy,
    output logic                  parity_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Control and read-path state
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  busy_q,  busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  oe_q,    oe_d;

    // Storage array; it has no reset and is cleared only by the sweep
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Decoded host requests; both are qualified by the READY state
    logic                  rd_req;
    logic                  wr_req;

    // Single write port shared by the sweep and host writes
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rword;

    assign rd_req    = (state_q == READY) && chip_select && !read_write_select;
    assign wr_req    = (state_q == READY) && chip_select &&  read_write_select;
    assign mem_rword = mem_q[address];

    // Next-state logic: the sweep counter in CLEAR, read capture in READY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        oe_d    = 1'b0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                if (rd_req) begin
                    rdata_d = mem_rword;
                    oe_d    = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control registers; async reset restarts the sweep from word 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            rdata_q <= '0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            oe_q    <= oe_d;
        end
    end

    // Write-port mux: the sweep owns the port in CLEAR, the host in READY
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = data_io;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr_req) begin
            mem_we    = 1'b1;
        end
    end

    // Memory array write; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

`ifdef SRAM_PARITY_EN
    // One even-parity bit per word, written alongside the data
    logic [DEPTH-1:0] par_q;
    logic             perr_q, perr_d;

    // Parity check is registered with the read word so both appear together
    always_comb begin
        perr_d = 1'b0;
        if (rd_req) begin
            perr_d = (^mem_rword) ^ par_q[address];
        end
    end

    // Parity storage; the sweep writes parity of zero, which is 0
    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_q[mem_waddr] <= ^mem_wdata;
        end
    end

    // Parity flag register; cleared on reset and on every non-read edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

    assign busy = busy_q;

    // The bus is gated combinationally by the live request so it releases
    // in the same cycle that chip_select drops or the host turns to write
    assign data_io = (oe_q && chip_select && !read_write_select) ?
                     rdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_1kx8_sync.sv
`timescale 1ns/1ps
// Directed bench for sram_1kx8_sync. A pull-up on every bus bit makes a
// released bus read as 0xFF.
module tb_sram_1kx8_sync;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] host_d;
    logic          host_oe;
    wire  [DW-1:0] data_io;
    logic          busy;
    logic          perr;

    int tests = 0;
    int fails = 0;

    assign data_io = host_oe ? host_d : {DW{1'bz}};

    for (genvar g = 0; g < DW; g++) begin : g_pu
        pullup (data_io[g]);
    end

    always #5 clk = ~clk;

    sram_1kx8_sync #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .chip_select      (cs),
        .read_write_select(rw),
        .address          (addr),
        .data_io          (data_io),
        .busy             (busy),
        .parity_error     (perr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        int bus_bad;
        rst = 1'b1; cs = 1'b1; rw = 1'b0; addr = '0; host_d = '0; host_oe = 1'b0;
        repeat (3) tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy); end
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL reset_bus_released: got %h expected ff", data_io); end
        tests++;
        if (perr !== 1'b0) begin fails++; $display("FAIL reset_parity: got %b expected 0", perr); end
        rst = 1'b0;
        n = 0; bus_bad = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
            if (data_io !== 8'hFF) bus_bad++;
        end
        tests++;
        if (n != 1024) begin fails++; $display("FAIL sweep_length: got %0d cycles expected 1024", n); end
        tests++;
        if (bus_bad != 0) begin fails++; $display("FAIL sweep_bus_hiz: got %0d driven cycles expected 0", bus_bad); end
        addr = 10'h3FF;
        tick();
        tests++;
        if (data_io !== 8'h00) begin fails++; $display("FAIL read_3ff_after_sweep: got %h expected 00", data_io); end
    endtask

    task automatic test_write_read_all();
        logic [DW-1:0] e;
        cs = 1'b1; rw = 1'b1; host_oe = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            addr = AW'(i);
            host_d = DW'(i * 2);
            tick();
        end
        rw = 1'b0; host_oe = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            addr = AW'(i);
            e = DW'(i * 2);
            tick();
            tests++;
            if (data_io !== e) begin fails++; $display("FAIL stream_read[%0d]: got %h expected %h", i, data_io, e); end
            tests++;
            if (perr !== 1'b0) begin fails++; $display("FAIL stream_parity[%0d]: got %b expected 0", i, perr); end
        end
        addr = 10'd5;
        tick();
        tests++;
        if (data_io !== 8'h0A) begin fails++; $display("FAIL read_addr5: got %h expected 0a", data_io); end
        addr = 10'd200;
        tick();
        tests++;
        if (data_io !== 8'h90) begin fails++; $display("FAIL read_addr200: got %h expected 90", data_io); end
    endtask

    task automatic test_turnaround();
        cs = 1'b1; rw = 1'b0; host_oe = 1'b0; addr = 10'd10;
        tick();
        tests++;
        if (data_io !== 8'h14) begin fails++; $display("FAIL turn_read10: got %h expected 14", data_io); end
        rw = 1'b1;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL turn_release: got %h expected ff", data_io); end
        host_d = 8'h55; host_oe = 1'b1;
        #1;
        tests++;
        if (data_io !== 8'h55) begin fails++; $display("FAIL turn_host_drive: got %h expected 55", data_io); end
        tick();
        host_oe = 1'b0; rw = 1'b0;
        tick();
        tests++;
        if (data_io !== 8'h55) begin fails++; $display("FAIL turn_readback: got %h expected 55", data_io); end
    endtask

    task automatic test_back_to_back();
        cs = 1'b1; rw = 1'b1; host_oe = 1'b1; host_d = 8'hA5; addr = 10'h123;
        tick();
        rw = 1'b0; host_oe = 1'b0;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL b2b_oe_after_write: got %h expected ff", data_io); end
        tick();
        tests++;
        if (data_io !== 8'hA5) begin fails++; $display("FAIL b2b_read_new: got %h expected a5", data_io); end
    endtask

    task automatic test_chip_deselect();
        cs = 1'b1; rw = 1'b0; host_oe = 1'b0; addr = 10'd7;
        tick();
        tests++;
        if (data_io !== 8'h0E) begin fails++; $display("FAIL cs_pre_read7: got %h expected 0e", data_io); end
        cs = 1'b0;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL cs_release: got %h expected ff", data_io); end
        rw = 1'b1; host_d = 8'hFF; host_oe = 1'b1;
        tick();
        host_oe = 1'b0; rw = 1'b0;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL cs_idle_hiz: got %h expected ff", data_io); end
        cs = 1'b1;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL cs_oe_cleared: got %h expected ff", data_io); end
        tick();
        tests++;
        if (data_io !== 8'h0E) begin fails++; $display("FAIL cs_mem7_kept: got %h expected 0e", data_io); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        cs = 1'b1; rw = 1'b0; host_oe = 1'b0; addr = 10'd5;
        tick();
        tests++;
        if (data_io !== 8'h0A) begin fails++; $display("FAIL mid_pre_read5: got %h expected 0a", data_io); end
        rst = 1'b1;
        #1;
        tests++;
        if (data_io !== 8'hFF) begin fails++; $display("FAIL mid_async_release: got %h expected ff", data_io); end
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_async_busy: got %b expected 1", busy); end
        tick();
        rst = 1'b0;
        repeat (500) tick();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_at_500: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        tests++;
        if (n != 1024) begin fails++; $display("FAIL mid_sweep_length: got %0d cycles expected 1024", n); end
        addr = 10'h123;
        tick();
        tests++;
        if (data_io !== 8'h00) begin fails++; $display("FAIL mid_cleared_123: got %h expected 00", data_io); end
        addr = 10'd10;
        tick();
        tests++;
        if (data_io !== 8'h00) begin fails++; $display("FAIL mid_cleared_10: got %h expected 00", data_io); end
    endtask

    task automatic test_parity();
        cs = 1'b1; rw = 1'b1; host_oe = 1'b1; host_d = 8'h3C; addr = 10'h050;
        tick();
        rw = 1'b0; host_oe = 1'b0;
        tick();
        tests++;
        if (data_io !== 8'h3C) begin fails++; $display("FAIL par_read: got %h expected 3c", data_io); end
        tests++;
        if (perr !== 1'b0) begin fails++; $display("FAIL par_clean: got %b expected 0", perr); end
`ifdef SRAM_PARITY_EN
        dut.mem_q[10'h050] = 8'h3D;
        tick();
        tests++;
        if (perr !== 1'b1) begin fails++; $display("FAIL par_flip_detect: got %b expected 1", perr); end
        cs = 1'b0;
        tick();
        tests++;
        if (perr !== 1'b0) begin fails++; $display("FAIL par_clear_idle: got %b expected 0", perr); end
        cs = 1'b1;
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read_all();
        test_turnaround();
        test_back_to_back();
        test_chip_deselect();
        test_reset_mid_sweep();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_1kx8_sync.md
Name: sram_1kx8_sync

Overview:
- Single-port, clocked 1K x 8 static RAM with one shared bidirectional data bus, chip select and a read/write select line.
- Used as a generic on-chip scratch memory.
- After reset, a built-in sweep clears every word before accesses are accepted.

Parameters:
- ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH (1024 words).
- DATA_WIDTH, 8, word width and data_io width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- chip_select  input  1  1 = device selected; 0 = idle, bus released.
- read_write_select  input  1  1 = write (bus driven by host), 0 = read (bus driven by RAM).
- address  input  ADDR_WIDTH  word address.
- data_io  inout  DATA_WIDTH  shared data bus; RAM drives only during reads, else high-Z.
- busy  output  1  1 while the post-reset clear sweep runs; accesses ignored.
- parity_error  output  1  read-parity flag (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- State machine has two states, CLEAR and READY.
- rst asserted (async):
  - state=CLEAR, clear counter=0, busy=1.
  - read-data register=0, output-enable register=0, parity_error=0.
  - data_io high-Z immediately.
- CLEAR:
  - Each clk writes 0 to mem[counter], then counter+1.
  - After writing the last word (counter = 2**ADDR_WIDTH-1), go to READY on the next edge.
  - Sweep takes exactly 1024 cycles; busy deasserts on the edge that enters READY.
  - Host accesses during CLEAR are ignored: no write, no bus drive.
- rst asserted mid-sweep: counter restarts at 0 and the sweep repeats in full.
- Memory array itself has no reset path; it is cleared only by the sweep.
- Write (READY, chip_select=1, read_write_select=1): mem[address] <= data_io on the rising edge. One word per cycle; back-to-back writes allowed.
- Read (READY, chip_select=1, read_write_select=0):
  - Rising edge captures mem[address] into the read-data register and sets output-enable.
  - data_io shows the word after that edge: 1-cycle latency.
  - Address changes each cycle give a pipelined stream, one word per cycle.
- Bus drive condition: data_io = read-data register only when output-enable=1 AND chip_select=1 AND read_write_select=0 (combinational gating).
  - Deasserting chip_select or switching to write releases the bus in the same cycle, with no contention on turnaround.
  - Output-enable clears on any edge where the read condition is false.
- Write followed by a read of the same address on the next cycle returns the new data (no stale read).
- Data written is stored exactly DATA_WIDTH bits; the host is responsible for truncation.
- chip_select=0: no state change except output-enable clearing; memory retained.
- X/Z on data_io during a write is stored as-is; not checked.

Optional Feature:
- Macro SRAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed from data_io on write and set to 0 by the sweep (parity of 0).
  - On each read capture, parity_error is registered as the XOR of stored data and parity bit; it stays valid alongside data_io.
  - parity_error clears on rst and on any non-read edge.
- Not defined: no parity storage, parity_error tied to 0.

Test Plan:
- Reset, then hold chip_select=1, read_write_select=0 -> busy=1 for exactly 1024 cycles, data_io high-Z throughout; after busy falls, reading address 0x3FF returns 0x00.
- Write mem[i] = (2*i) mod 256 for i=0..1023, then read i=0..1023 -> data_io = (2*i) mod 256 one cycle after each address (e.g. addr 5 -> 0x0A, addr 200 -> 0x90).
- Read addr 10 then switch read_write_select to 1 in the same cycle the host drives 0x55 -> DUT releases data_io combinationally, with no bus contention.
- Write 0xA5 to addr 0x123, then read addr 0x123 on the next cycle -> 0xA5 after 1 cycle.
- chip_select=0 with read_write_select=1 and data 0xFF on addr 7 -> mem[7] unchanged, bus stays high-Z.
- Assert rst at sweep count 500 -> busy stays 1 for 1024 cycles from release; with SRAM_PARITY_EN, a force-flipped bit on read -> parity_error=1.
